// File: rtl/if_line_cache.sv
// Direct-mapped instruction-fetch cache with multi-word lines refilled one word per memory handshake.
// Hits and the in-flight critical word are returned combinationally; flush_i invalidates every line.
module if_line_cache #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned INST_W     = 32,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  input  logic              flush_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              inst_valid_o,
  output logic              if_stall_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_done_i,
  input  logic [INST_W-1:0] mem_data_i
);

  localparam int unsigned OFF_BITS = $clog2(LINE_WORDS);
  localparam int unsigned CNT_W    = (OFF_BITS == 0) ? 1 : OFF_BITS;
  localparam int unsigned WA_W     = ADDR_W - 2;
  localparam int unsigned TAG_W    = WA_W - INDEX_BITS - OFF_BITS;
  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned DA_W     = INDEX_BITS + OFF_BITS;
  localparam int unsigned WORDS    = LINES * LINE_WORDS;

  localparam logic [CNT_W-1:0] OFF_MASK = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] REFILL = 1'b1;

  // Word-address view of the request: {tag, idx, off}
  logic [WA_W-1:0]       pc_wa;
  logic [INDEX_BITS-1:0] pc_idx;
  logic [TAG_W-1:0]      pc_tag;
  logic [DA_W-1:0]       pc_da;

  assign pc_wa  = pc_i[ADDR_W-1:2];
  assign pc_idx = pc_wa[OFF_BITS +: INDEX_BITS];
  assign pc_tag = pc_wa[WA_W-1 -: TAG_W];
  assign pc_da  = pc_wa[DA_W-1:0];

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [INST_W-1:0] data_mem [WORDS];

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WA_W-1:0]  base_q, base_d;

  logic start_fill, word_wr, line_done;
  logic hit_c, fwd_c, in_fill_c;

  logic [WA_W-1:0]       fill_wa;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [DA_W-1:0]       fill_da;

  // Word under refill: counter offset within the latched line base, never crossing the line
  assign fill_wa   = base_q | WA_W'(cnt_q & OFF_MASK);
  assign fill_idx  = base_q[OFF_BITS +: INDEX_BITS];
  assign fill_da   = fill_wa[DA_W-1:0];
  assign in_fill_c = (state_q == REFILL);

  assign hit_c = rst & pc_valid_i & ~flush_i & valid_q[pc_idx] & (tag_mem[pc_idx] == pc_tag);
  assign fwd_c = rst & in_fill_c & mem_done_i & pc_valid_i & ~flush_i & (pc_wa == fill_wa);

  // Next-state and storage strobes
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    start_fill = 1'b0;
    word_wr    = 1'b0;
    line_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pc_valid_i && !hit_c) begin
          start_fill = 1'b1;
          base_d     = pc_wa & ~WA_W'(OFF_MASK);
          cnt_d      = '0;
          state_d    = REFILL;
        end
      end
      REFILL: begin
        if (mem_done_i) begin
          word_wr = 1'b1;
          if (cnt_q == LAST_CNT) begin
            line_done = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush and reset abort everything, including a coincident miss or returned word
    if (!rst || flush_i) begin
      start_fill = 1'b0;
      word_wr    = 1'b0;
      line_done  = 1'b0;
      state_d    = IDLE;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
    end
  end

  // A line is invalid for the whole refill and becomes valid with its last word
  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      valid_q <= '0;
    end else begin
      if (start_fill) valid_q[pc_idx] <= 1'b0;
      if (line_done)  valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (start_fill) tag_mem[pc_idx] <= pc_tag;
    if (word_wr)    data_mem[fill_da] <= mem_data_i;
  end

  assign inst_valid_o = hit_c | fwd_c;
  assign inst_o       = hit_c ? data_mem[pc_da] : (fwd_c ? mem_data_i : '0);
  assign pc_o         = inst_valid_o ? pc_i : '0;
  assign if_stall_o   = rst & pc_valid_i & ~inst_valid_o;
  assign mem_req_o    = rst & in_fill_c;
  assign mem_addr_o   = mem_req_o ? {fill_wa, 2'b00} : '0;

  logic unused_c;
  assign unused_c = ^pc_i[1:0];

endmodule

// File: tb/tb_if_line_cache.sv
// Self-checking bench for if_line_cache: table of hit lookups plus hand-written refill,
// eviction, flush and reset sequences; fetched words are scored through an expectation queue.
module tb_if_line_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        flush_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_valid_o;
  logic        if_stall_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_done_i;
  logic [31:0] mem_data_i;

  if_line_cache dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .flush_i(flush_i),
    .inst_o(inst_o), .pc_o(pc_o), .inst_valid_o(inst_valid_o), .if_stall_o(if_stall_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_done_i(mem_done_i),
    .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic        pv;
    logic        exp_hit;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Backing memory contents; address 0 holds the first instruction of the program
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:2] == 30'd0) return 32'h0010_0093;
    return {a[15:0] ^ 16'h5a5a, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive after posedge, score combinational and registered outputs before the next edge
  task automatic step(input logic r, input logic [31:0] pc, input logic pv, input logic fl,
                      input logic dn, input logic [31:0] dat, input logic eh,
                      input logic er, input logic [31:0] ea, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; pc_i = pc; pc_valid_i = pv; flush_i = fl; mem_done_i = dn; mem_data_i = dat;
    if (eh) sb.push_back('{pc, mem_word(pc)});
    #3;
    check({name, ".valid"}, 32'(inst_valid_o), 32'(eh));
    if (inst_valid_o) begin
      if (sb.size() == 0) begin
        check({name, ".unexpected_fetch"}, pc_o, 32'hffff_ffff);
      end else begin
        e = sb.pop_front();
        check({name, ".pc_o"}, pc_o, e.pc);
        check({name, ".inst_o"}, inst_o, e.inst);
      end
    end else begin
      if (eh && sb.size() != 0) void'(sb.pop_front());
      check({name, ".inst_o_idle"}, inst_o, 32'h0);
      check({name, ".pc_o_idle"}, pc_o, 32'h0);
    end
    check({name, ".stall"}, 32'(if_stall_o), 32'(r && pv && !eh));
    check({name, ".mem_req"}, 32'(mem_req_o), 32'(er));
    check({name, ".mem_addr"}, mem_addr_o, er ? ea : 32'h0);
  endtask

  // Return `count` words of the line at `base` starting at word `first`, one handshake per cycle
  task automatic fill_words(input logic [31:0] base, input int first, input int count,
                            input logic [31:0] pc, input logic pv, input string name);
    logic [31:0] a;
    for (int w = first; w < first + count; w++) begin
      a = base + 32'(4 * w);
      step(1'b1, pc, pv, 1'b0, 1'b1, mem_word(a), pv && (pc[31:2] == a[31:2]), 1'b1, a, name);
    end
  endtask

  task automatic miss(input logic [31:0] pc, input string name);
    step(1'b1, pc, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, name);
  endtask

  initial begin
    rst = 1'b0; pc_i = 32'h0; pc_valid_i = 1'b1; flush_i = 1'b0;
    mem_done_i = 1'b0; mem_data_i = 32'h0;

    vecs[0] = '{32'h0000_0000, 1'b1, 1'b1};
    vecs[1] = '{32'h0000_0004, 1'b1, 1'b1};
    vecs[2] = '{32'h0000_000C, 1'b1, 1'b1};
    vecs[3] = '{32'h0000_0014, 1'b1, 1'b1};
    vecs[4] = '{32'h0000_001C, 1'b1, 1'b1};
    vecs[5] = '{32'h0000_0020, 1'b1, 1'b1};
    vecs[6] = '{32'h0000_002C, 1'b1, 1'b1};
    vecs[7] = '{32'h0000_0008, 1'b0, 1'b0};
    vecs[8] = '{32'h0000_0104, 1'b0, 1'b0};

    // Reset holds every output low even with a request present
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hdead_beef, 1'b0, 1'b0, 32'h0, "reset0");
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "reset1");

    // Cold miss at 0x0: request appears next cycle and holds until done; critical word forwarded
    miss(32'h0, "cold_miss");
    step(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, "req_hold");
    fill_words(32'h0, 0, 4, 32'h0, 1'b1, "fill0");
    step(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, "hit_0x8");

    // Second line with critical word mid-line, third line with the pc redirected elsewhere
    miss(32'h18, "miss_0x18");
    fill_words(32'h10, 0, 4, 32'h18, 1'b1, "fill10");
    miss(32'h20, "miss_0x20");
    fill_words(32'h20, 0, 4, 32'h104, 1'b1, "fill20_redirect");

    // Table of lookups against the three resident lines
    for (int i = 0; i < 9; i++)
      step(1'b1, vecs[i].pc, vecs[i].pv, 1'b0, 1'b0, 32'h0, vecs[i].exp_hit, 1'b0, 32'h0,
           $sformatf("vec%0d", i));

    // Same index, different tag: 0x400 evicts line 0, then 0x0 misses again
    miss(32'h400, "miss_0x400");
    fill_words(32'h400, 0, 4, 32'h400, 1'b1, "fill400");
    step(1'b1, 32'h404, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, "hit_0x404");
    miss(32'h0, "evicted_0x0");

    // Flush coincident with the last word: word dropped, line stays invalid, 0x0 refills
    fill_words(32'h0, 0, 3, 32'h0, 1'b1, "fill0_pre_flush");
    step(1'b1, 32'hC, 1'b1, 1'b1, 1'b1, mem_word(32'hC), 1'b0, 1'b1, 32'hC, "flush_on_last");
    miss(32'h0, "post_flush_0x0");
    fill_words(32'h0, 0, 4, 32'h0, 1'b1, "refill0");
    step(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, "hit_0x8_again");
    step(1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "flushed_0x14");

    // Reset with cnt=2 aborts the refill and drops every resident line
    fill_words(32'h10, 0, 2, 32'h10, 1'b1, "fill10_partial");
    step(1'b0, 32'h18, 1'b1, 1'b0, 1'b1, mem_word(32'h18), 1'b0, 1'b0, 32'h0, "reset_mid_fill");
    step(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "post_reset_0x8");
    fill_words(32'h0, 0, 4, 32'h8, 1'b1, "refill0_after_reset");
    step(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, "hit_0xC");

    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
